// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding mux encodings, stall FSM state type
// and the priority helper used by the per-operand forwarding compare.
package pipe_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } stall_state_t;

   // EX/MEM holds the younger result, so it beats MEM/WB when both match
   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic wb_hit);
      if (ex_hit) return FWD_EXMEM;
      if (wb_hit) return FWD_MEMWB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-register side bundle of the forwarding/hazard unit: the pipeline
// (master) drives stage addresses and controls, the unit (slave) answers.
interface fwd_hazard_unit_if
   import pipe_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
);

   logic                      flush_i;
   logic                      id_valid_i;
   logic [NUM_SRC*REG_AW-1:0] id_src_i;
   logic [NUM_SRC-1:0]        id_src_used_i;
   logic [NUM_SRC*REG_AW-1:0] id_ex_src_i;
   logic [REG_AW-1:0]         id_ex_rd_i;
   logic                      id_ex_memread_i;
   logic [REG_AW-1:0]         ex_mem_rd_i;
   logic                      ex_mem_regwrite_i;
   logic [REG_AW-1:0]         mem_wb_rd_i;
   logic                      mem_wb_regwrite_i;

   logic [NUM_SRC*2-1:0]      fwd_sel_o;
   logic                      pc_write_o;
   logic                      if_id_write_o;
   logic                      id_ex_flush_o;
   logic                      stalling_o;
   logic [CNT_W-1:0]          hazard_cnt_o;
   logic [CNT_W-1:0]          stall_cnt_o;

   modport master (
      output flush_i, id_valid_i, id_src_i, id_src_used_i, id_ex_src_i,
             id_ex_rd_i, id_ex_memread_i, ex_mem_rd_i, ex_mem_regwrite_i,
             mem_wb_rd_i, mem_wb_regwrite_i,
      input  fwd_sel_o, pc_write_o, if_id_write_o, id_ex_flush_o,
             stalling_o, hazard_cnt_o, stall_cnt_o
   );

   modport slave (
      input  flush_i, id_valid_i, id_src_i, id_src_used_i, id_ex_src_i,
             id_ex_rd_i, id_ex_memread_i, ex_mem_rd_i, ex_mem_regwrite_i,
             mem_wb_rd_i, mem_wb_regwrite_i,
      output fwd_sel_o, pc_write_o, if_id_write_o, id_ex_flush_o,
             stalling_o, hazard_cnt_o, stall_cnt_o
   );

endinterface

// File: rtl/fwd_sel_one.sv
// Single-operand forwarding select: compares one EX-stage source against the
// EX/MEM and MEM/WB destinations. Register 0 is hard-wired and never forwarded.
module fwd_sel_one
   import pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic              ex_mem_regwrite,
   input  logic [REG_AW-1:0] mem_wb_rd,
   input  logic              mem_wb_regwrite,
   output logic [1:0]        sel
);

   logic ex_hit;
   logic wb_hit;

   assign ex_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == src);
   assign wb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src);
   assign sel    = fwd_pick(ex_hit, wb_hit);

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding for NUM_SRC operands plus load-use hazard
// detection with a LOAD_LAT-cycle stall FSM and saturating event counters.
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   fwd_hazard_unit_if.slave  bus
);

   localparam int                SCNT_W    = $clog2(LOAD_LAT + 1);
   localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(LOAD_LAT - 1);
   localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

   logic [NUM_SRC-1:0][REG_AW-1:0] ex_src;
   logic [NUM_SRC-1:0][REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0][1:0]        sel_raw;

   stall_state_t      state;
   logic [SCNT_W-1:0] scnt;
   logic [CNT_W-1:0]  hazard_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic              src_hit;
   logic              hz;
   logic              stall_act;

   assign ex_src = bus.id_ex_src_i;
   assign id_src = bus.id_src_i;

   // ---------------- forwarding ----------------
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
      fwd_sel_one #(.REG_AW(REG_AW)) u_sel (
         .src             (ex_src[k]),
         .ex_mem_rd       (bus.ex_mem_rd_i),
         .ex_mem_regwrite (bus.ex_mem_regwrite_i),
         .mem_wb_rd       (bus.mem_wb_rd_i),
         .mem_wb_regwrite (bus.mem_wb_regwrite_i),
         .sel             (sel_raw[k])
      );
   end

   assign bus.fwd_sel_o = rst_i ? sel_raw : '0;

   // ---------------- load-use detect ----------------
   always_comb begin
      src_hit = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.id_src_used_i[k] && (id_src[k] == bus.id_ex_rd_i)) src_hit = 1'b1;
      end
   end

   // a flushed ID slot is being discarded anyway, so it cannot cause a stall
   assign hz = bus.id_valid_i & bus.id_ex_memread_i & (bus.id_ex_rd_i != '0) &
               ~bus.flush_i & src_hit;

   // the first stall cycle is the detect cycle itself, hence the IDLE & hz term
   assign stall_act = rst_i & (((state == ST_IDLE) & hz) | (state == ST_STALL));

   assign bus.pc_write_o    = ~stall_act;
   assign bus.if_id_write_o = ~stall_act;
   assign bus.id_ex_flush_o = rst_i & (stall_act | bus.flush_i);
   assign bus.stalling_o    = stall_act;
   assign bus.hazard_cnt_o  = hazard_cnt;
   assign bus.stall_cnt_o   = stall_cnt;

   // ---------------- stall FSM + statistics ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_IDLE;
         scnt       <= '0;
         hazard_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (stall_act && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (hz) begin
                  if (hazard_cnt != '1) hazard_cnt <= hazard_cnt + 1'b1;
                  if (LOAD_LAT > 1) begin
                     state <= ST_STALL;
                     scnt  <= SCNT_INIT;
                  end
               end
            end
            ST_STALL: begin
               if (bus.flush_i || (scnt == SCNT_ONE)) begin
                  state <= ST_IDLE;
                  scnt  <= '0;
               end else begin
                  scnt  <= scnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               scnt  <= '0;
            end
         endcase
      end
   end

endmodule
